// File: rtl/score_to_chars.sv
// Sequential binary-to-ASCII formatter: iterative double-dabble, one input bit per clock,
// with the last completed result held stable on chars/overflow for the text renderer.
module score_to_chars #(
  parameter int         DIGITS        = 4,
  parameter int         BIN_W         = 14,
  parameter bit         LEADING_ZEROS = 1'b0,
  parameter logic [7:0] PAD_CHAR      = 8'h20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BIN_W-1:0]       value_in,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [DIGITS-1:0][7:0] chars
);

  localparam int         BCD_W  = 4 * DIGITS;
  localparam int         CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [63:0] LIMIT = 64'(10 ** DIGITS);
  localparam logic [63:0] SPAN  = 64'd1 << BIN_W;
  // The range compare is only meaningful when the input can actually exceed the display.
  localparam bit         DO_CMP = (LIMIT < SPAN);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t             state_r;
  logic [BIN_W-1:0]   bin_r;
  logic [BCD_W-1:0]   bcd_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               sticky_r;
  logic [BCD_W-1:0]   adj_s;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

  // chars[0] is the most significant digit; blanking stops at the first nonzero digit
  // and the least significant position always shows a digit.
  function automatic logic [DIGITS-1:0][7:0] fmt_chars(input logic [BCD_W-1:0] bcd,
                                                        input logic ovf);
    logic [DIGITS-1:0][7:0] c;
    logic                   lead;
    logic [3:0]             nib;
    c    = '0;
    lead = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      nib = bcd[4*(DIGITS-1-i) +: 4];
      if (ovf) begin
        c[i] = 8'h39;
      end else if (!LEADING_ZEROS && lead && (nib == 4'd0) && (i != DIGITS - 1)) begin
        c[i] = PAD_CHAR;
      end else begin
        c[i] = {4'h3, nib};
        lead = 1'b0;
      end
    end
    return c;
  endfunction

  // Decimal-adjust step applied before every shift.
  always_comb begin
    adj_s = add3(bcd_r);
  end

  // Conversion FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      bin_r    <= '0;
      bcd_r    <= '0;
      cnt_r    <= '0;
      sticky_r <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      chars    <= fmt_chars({BCD_W{1'b0}}, 1'b0);
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            bin_r    <= value_in;
            bcd_r    <= '0;
            cnt_r    <= CNT_W'(BIN_W - 1);
            sticky_r <= DO_CMP && (64'(value_in) >= LIMIT);
            busy     <= 1'b1;
            state_r  <= SHIFT;
          end else begin
            state_r  <= IDLE;
          end
        end
        SHIFT: begin
          // Bits leaving the top of the BCD register mean the value does not fit.
          bcd_r    <= {adj_s[BCD_W-2:0], bin_r[BIN_W-1]};
          bin_r    <= {bin_r[BIN_W-2:0], 1'b0};
          sticky_r <= sticky_r | adj_s[BCD_W-1];
          cnt_r    <= cnt_r - CNT_W'(1);
          if (cnt_r == '0) begin
            state_r <= LOAD;
          end else begin
            state_r <= SHIFT;
          end
        end
        LOAD: begin
          chars    <= fmt_chars(bcd_r, sticky_r);
          overflow <= sticky_r;
          done     <= 1'b1;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_to_chars.sv
// Self-checking bench for score_to_chars: table vectors, random values against a
// decimal-arithmetic model, and hand-written back-to-back / reset-abort sequences.
module tb_score_to_chars;

  logic              clk = 1'b0;
  logic              rst;
  logic [13:0]       value_in;
  logic              start;
  logic              busy0, done0, ovf0;
  logic              busy1, done1, ovf1;
  logic [3:0][7:0]   chars0, chars1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_to_chars #(.DIGITS(4), .BIN_W(14), .LEADING_ZEROS(1'b0), .PAD_CHAR(8'h20)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .start(start),
    .busy(busy0), .done(done0), .overflow(ovf0), .chars(chars0)
  );

  score_to_chars #(.DIGITS(4), .BIN_W(14), .LEADING_ZEROS(1'b1), .PAD_CHAR(8'h20)) dut_lz (
    .clk(clk), .rst(rst), .value_in(value_in), .start(start),
    .busy(busy1), .done(done1), .overflow(ovf1), .chars(chars1)
  );

  typedef struct {
    int          v;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic        ovf;
  } vec_t;

  // Characters in reading order: chars[0] ends up in the top byte.
  function automatic logic [31:0] rd(input logic [3:0][7:0] c);
    return {c[0], c[1], c[2], c[3]};
  endfunction

  function automatic logic [31:0] model(input int v, input bit lz);
    logic [31:0] r;
    bit          lead;
    int          p, d;
    r    = 32'h0;
    lead = 1'b1;
    p    = 1000;
    if (v >= 10000) return 32'h39393939;
    for (int k = 0; k < 4; k++) begin
      d = (v / p) % 10;
      if (!lz && lead && d == 0 && k != 3) r[31-8*k -: 8] = 8'h20;
      else begin
        r[31-8*k -: 8] = 8'(8'h30 + d);
        lead = 1'b0;
      end
      p = p / 10;
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Wait for done (bounded), counting busy cycles and watching chars stay put.
  task automatic wait_done(input logic [31:0] prev0, input logic [31:0] prev1, input bit scramble);
    int nb = 0;
    int n  = 0;
    bit stable = 1'b1;
    while (!done0 && n < 40) begin
      if (busy0) nb++;
      if (rd(chars0) !== prev0 || rd(chars1) !== prev1) stable = 1'b0;
      if (scramble) value_in = 14'($urandom);
      @(negedge clk);
      n++;
    end
    check("busy_cycles", 32'(nb), 32'd15);
    check("done_seen", {31'd0, done0}, 32'd1);
    check("done_lz_seen", {31'd0, done1}, 32'd1);
    check("busy_low_at_done", {31'd0, busy0}, 32'd0);
    check("chars_stable_shift", {31'd0, stable}, 32'd1);
  endtask

  task automatic convert(input int v);
    logic [31:0] p0, p1;
    p0 = rd(chars0);
    p1 = rd(chars1);
    @(negedge clk);
    value_in = 14'(v);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(p0, p1, 1'b1);
  endtask

  task automatic check_result(input string nm, input logic [31:0] e0, input logic [31:0] e1,
                              input logic eo);
    check({nm, "_chars"}, rd(chars0), e0);
    check({nm, "_chars_lz"}, rd(chars1), e1);
    check({nm, "_ovf"}, {31'd0, ovf0}, {31'd0, eo});
    check({nm, "_ovf_lz"}, {31'd0, ovf1}, {31'd0, eo});
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1234,  32'h31323334, 32'h31323334, 1'b0};
    vecs[1]  = '{7,     32'h20202037, 32'h30303037, 1'b0};
    vecs[2]  = '{12000, 32'h39393939, 32'h39393939, 1'b1};
    vecs[3]  = '{0,     32'h20202030, 32'h30303030, 1'b0};
    vecs[4]  = '{9999,  32'h39393939, 32'h39393939, 1'b0};
    vecs[5]  = '{10000, 32'h39393939, 32'h39393939, 1'b1};
    vecs[6]  = '{16383, 32'h39393939, 32'h39393939, 1'b1};
    vecs[7]  = '{1000,  32'h31303030, 32'h31303030, 1'b0};
    vecs[8]  = '{5,     32'h20202035, 32'h30303035, 1'b0};
    vecs[9]  = '{90,    32'h20203930, 32'h30303930, 1'b0};
    vecs[10] = '{405,   32'h20343035, 32'h30343035, 1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    value_in = 14'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_chars", rd(chars0), 32'h20202030);
    check("reset_chars_lz", rd(chars1), 32'h30303030);
    check("reset_busy", {31'd0, busy0}, 32'd0);
    check("reset_done", {31'd0, done0}, 32'd0);
    check("reset_ovf", {31'd0, ovf0}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      convert(vecs[i].v);
      check_result($sformatf("vec%0d", vecs[i].v), vecs[i].exp0, vecs[i].exp1, vecs[i].ovf);
      @(negedge clk);
      check("done_one_cycle", {31'd0, done0}, 32'd0);
    end

    for (int i = 0; i < 30; i++) begin
      int v;
      v = int'($urandom_range(0, 16383));
      convert(v);
      check_result($sformatf("rand%0d", v), model(v, 1'b0), model(v, 1'b1), v >= 10000);
    end

    // Back-to-back: start held through the conversion, value changed after acceptance.
    begin
      logic [31:0] p0, p1;
      p0 = rd(chars0);
      p1 = rd(chars1);
      @(negedge clk);
      value_in = 14'd1234;
      start    = 1'b1;
      @(negedge clk);
      value_in = 14'd5678;
      wait_done(p0, p1, 1'b0);
      check_result("hold1234", 32'h31323334, 32'h31323334, 1'b0);
      @(negedge clk);
      check("b2b_accepted_busy", {31'd0, busy0}, 32'd1);
      check("b2b_done_low", {31'd0, done0}, 32'd0);
      start = 1'b0;
      p0 = rd(chars0);
      p1 = rd(chars1);
      begin
        int n = 0;
        while (!done0 && n < 40) begin
          if (rd(chars0) !== p0) n = 100;
          @(negedge clk);
          n++;
        end
        check("b2b_done_seen", {31'd0, done0}, 32'd1);
      end
      check_result("b2b5678", 32'h35363738, 32'h35363738, 1'b0);
    end

    // Reset abort in the fifth SHIFT cycle.
    begin
      bit quiet = 1'b1;
      @(negedge clk);
      value_in = 14'd9999;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_result("abort", 32'h20202030, 32'h30303030, 1'b0);
      check("abort_busy", {31'd0, busy0}, 32'd0);
      check("abort_done", {31'd0, done0}, 32'd0);
      for (int i = 0; i < 20; i++) begin
        if (done0 || busy0 || done1 || busy1) quiet = 1'b0;
        @(negedge clk);
      end
      check("abort_no_done", {31'd0, quiet}, 32'd1);
      convert(9999);
      check_result("after_abort", 32'h39393939, 32'h39393939, 1'b0);
      convert(42);
      check_result("after_abort42", 32'h20203432, 32'h30303432, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
